// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host transmitter states, error codes, command bytes
// and frame helpers.
package ps2_pkg;

   typedef enum logic [3:0] {
      IDLE,
      INHIBIT,
      SETUP,
      WAIT_CLK,
      SEND,
      ACK,
      WAIT_IDLE,
      DONE,
      ERR
   } txState_e;

   localparam logic [1:0] ERR_NONE     = 2'b00;
   localparam logic [1:0] ERR_NOACK    = 2'b01;
   localparam logic [1:0] ERR_START_TO = 2'b10;
   localparam logic [1:0] ERR_PKT_TO   = 2'b11;

   localparam logic [7:0] CMD_SET_LED   = 8'hED;
   localparam logic [7:0] CMD_RESET     = 8'hFF;
   localparam logic [7:0] CMD_ENABLE    = 8'hF4;
   localparam logic [7:0] CMD_TYPEMATIC = 8'hF3;

   localparam logic [3:0] PARITY_IDX = 4'd8;

   function automatic logic oddParity(input logic [7:0] b);
      return ~^b;
   endfunction

   // Line level for frame position idx: 0..7 data LSB first, 8 parity, 9 stop.
   function automatic logic frameBit(input logic [7:0] b, input logic par, input logic [3:0] idx);
      if (idx < 4'd8)
         return b[idx[2:0]];
      else if (idx == PARITY_IDX)
         return par;
      else
         return 1'b1;
   endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Synchronizes the raw PS/2 clock and data lines and flags clock falling edges.
module ps2_line_sync (
   input  logic clk,
   input  logic reset_n,
   input  logic ps2_clk_in,
   input  logic ps2_data_in,
   output logic clkSync,
   output logic dataSync,
   output logic clkFall_c
);

   logic [2:0] clkPipe;
   logic [1:0] dataPipe;

   // Idle PS/2 lines are high, so reset to 1 to avoid a spurious edge.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         clkPipe  <= '1;
         dataPipe <= '1;
      end else begin
         clkPipe  <= {clkPipe[1:0], ps2_clk_in};
         dataPipe <= {dataPipe[0], ps2_data_in};
      end
   end

   assign clkSync   = clkPipe[1];
   assign dataSync  = dataPipe[1];
   assign clkFall_c = clkPipe[2] & ~clkPipe[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, bit shift
// on device clock edges, ACK check, with start and packet timeouts.
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int unsigned INHIBIT_CYCLES = 6000,
   parameter int unsigned SETUP_CYCLES   = 50,
   parameter int unsigned START_TIMEOUT  = 750000,
   parameter int unsigned PACKET_TIMEOUT = 100000
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       tx_busy,
   output logic       tx_done,
   output logic       tx_err,
   output logic [1:0] err_code,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe
);

   localparam int unsigned TO_MAX    = (START_TIMEOUT > PACKET_TIMEOUT) ? START_TIMEOUT : PACKET_TIMEOUT;
   localparam int unsigned PHASE_MAX = (INHIBIT_CYCLES > SETUP_CYCLES) ? INHIBIT_CYCLES : SETUP_CYCLES;
   localparam int unsigned CNT_MAX   = (TO_MAX > PHASE_MAX) ? TO_MAX : PHASE_MAX;
   localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] CNT_SAT     = '1;
   localparam logic [CNT_W-1:0] INHIBIT_END = CNT_W'(INHIBIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] SETUP_END   = CNT_W'(SETUP_CYCLES - 1);
   localparam logic [CNT_W-1:0] START_END   = CNT_W'(START_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] PKT_END     = CNT_W'(PACKET_TIMEOUT - 1);

   txState_e         state, stateNext;
   logic [CNT_W-1:0] cnt, cntNext;
   logic [3:0]       bitIdx, bitIdxNext;
   logic [7:0]       dataReg, dataNext;
   logic             parityReg, parityNext;
   logic [1:0]       errCodeNext;
   logic             readyNext, busyNext, doneNext, errNext, clkOeNext, dataOeNext;
   logic             clkSync, dataSync, clkFall_c;
   logic             pktTimeout_c;

   ps2_line_sync u_sync (
      .clk        (clk),
      .reset_n    (reset_n),
      .ps2_clk_in (ps2_clk_in),
      .ps2_data_in(ps2_data_in),
      .clkSync    (clkSync),
      .dataSync   (dataSync),
      .clkFall_c  (clkFall_c)
   );

   assign pktTimeout_c = (cnt == PKT_END);

   // Next state; a device clock edge always beats a coincident timeout.
   always_comb begin
      stateNext   = state;
      cntNext     = (cnt == CNT_SAT) ? cnt : cnt + CNT_W'(1);
      bitIdxNext  = bitIdx;
      dataNext    = dataReg;
      parityNext  = parityReg;
      errCodeNext = ERR_NONE;
      readyNext   = 1'b0;
      busyNext    = 1'b0;
      doneNext    = 1'b0;
      errNext     = 1'b0;
      clkOeNext   = 1'b0;
      dataOeNext  = 1'b0;

      case (state)
         IDLE: begin
            cntNext = '0;
            if (tx_valid && tx_ready) begin
               stateNext  = INHIBIT;
               dataNext   = tx_data;
               parityNext = oddParity(tx_data);
            end
         end
         INHIBIT: begin
            if (cnt == INHIBIT_END) begin
               stateNext = SETUP;
               cntNext   = '0;
            end
         end
         SETUP: begin
            if (cnt == SETUP_END) begin
               stateNext = WAIT_CLK;
               cntNext   = '0;
            end
         end
         WAIT_CLK: begin
            if (clkFall_c) begin
               stateNext  = SEND;
               bitIdxNext = '0;
               cntNext    = '0;
            end else if (cnt == START_END) begin
               stateNext   = ERR;
               errCodeNext = ERR_START_TO;
            end
         end
         SEND: begin
            if (clkFall_c) begin
               bitIdxNext = bitIdx + 4'd1;
               if (bitIdx == PARITY_IDX)
                  stateNext = ACK;
            end else if (pktTimeout_c) begin
               stateNext   = ERR;
               errCodeNext = ERR_PKT_TO;
            end
         end
         ACK: begin
            if (clkFall_c) begin
               if (dataSync) begin
                  stateNext   = ERR;
                  errCodeNext = ERR_NOACK;
               end else begin
                  stateNext = WAIT_IDLE;
               end
            end else if (pktTimeout_c) begin
               stateNext   = ERR;
               errCodeNext = ERR_PKT_TO;
            end
         end
         WAIT_IDLE: begin
            if (clkSync && dataSync) begin
               stateNext = DONE;
            end else if (pktTimeout_c) begin
               stateNext   = ERR;
               errCodeNext = ERR_PKT_TO;
            end
         end
         DONE, ERR: begin
            stateNext = IDLE;
            cntNext   = '0;
         end
         default: begin
            stateNext = IDLE;
            cntNext   = '0;
         end
      endcase

      // Outputs are decoded from the next state and registered alongside it.
      readyNext = (stateNext == IDLE);
      busyNext  = (stateNext inside {INHIBIT, SETUP, WAIT_CLK, SEND, ACK, WAIT_IDLE});
      doneNext  = (stateNext == DONE);
      errNext   = (stateNext == ERR);
      clkOeNext = (stateNext inside {INHIBIT, SETUP});
      case (stateNext)
         SETUP, WAIT_CLK: dataOeNext = 1'b1;
         SEND:            dataOeNext = ~frameBit(dataNext, parityNext, bitIdxNext);
         default:         dataOeNext = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state       <= IDLE;
         cnt         <= '0;
         bitIdx      <= '0;
         dataReg     <= '0;
         parityReg   <= 1'b0;
         tx_ready    <= 1'b1;
         tx_busy     <= 1'b0;
         tx_done     <= 1'b0;
         tx_err      <= 1'b0;
         err_code    <= ERR_NONE;
         ps2_clk_oe  <= 1'b0;
         ps2_data_oe <= 1'b0;
      end else begin
         state       <= stateNext;
         cnt         <= cntNext;
         bitIdx      <= bitIdxNext;
         dataReg     <= dataNext;
         parityReg   <= parityNext;
         tx_ready    <= readyNext;
         tx_busy     <= busyNext;
         tx_done     <= doneNext;
         tx_err      <= errNext;
         err_code    <= errCodeNext;
         ps2_clk_oe  <= clkOeNext;
         ps2_data_oe <= dataOeNext;
      end
   end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: table of command frames against an open-drain
// keyboard model, plus timeout, reset and back-to-back sequences.
module tb_ps2_host_tx;
   import ps2_pkg::*;

   localparam int unsigned INH      = 6000;
   localparam int unsigned SET      = 50;
   localparam int unsigned START_TO = 2000;
   localparam int unsigned PKT_TO   = 3000;
   localparam int          HALF     = 20;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_ready, tx_busy, tx_done, tx_err;
   logic [1:0] err_code;
   logic       ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
   logic       devClkLow = 1'b0;
   logic       devDataLow = 1'b0;

   // Open-drain wired-AND of host and keyboard.
   assign ps2_clk_in  = ~(ps2_clk_oe | devClkLow);
   assign ps2_data_in = ~(ps2_data_oe | devDataLow);

   ps2_host_tx #(
      .INHIBIT_CYCLES(INH),
      .SETUP_CYCLES  (SET),
      .START_TIMEOUT (START_TO),
      .PACKET_TIMEOUT(PKT_TO)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .tx_busy    (tx_busy),
      .tx_done    (tx_done),
      .tx_err     (tx_err),
      .err_code   (err_code),
      .ps2_clk_in (ps2_clk_in),
      .ps2_data_in(ps2_data_in),
      .ps2_clk_oe (ps2_clk_oe),
      .ps2_data_oe(ps2_data_oe)
   );

   always #5 clk = ~clk;

   // Pulse monitor
   int         cyc = 0, doneTotal = 0, errTotal = 0, doneCyc = 0, oeRiseCyc = 0;
   logic [1:0] lastErrCode = 2'b00, oeAtErr = 2'b00, oeAfterErr = 2'b00;
   logic       readyAfterErr = 1'b0, readyAtDone = 1'b0, errPrev = 1'b0, clkOePrev = 1'b0;

   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (tx_done) begin
         doneTotal   <= doneTotal + 1;
         doneCyc     <= cyc;
         readyAtDone <= tx_ready;
      end
      if (tx_err) begin
         errTotal    <= errTotal + 1;
         lastErrCode <= err_code;
         oeAtErr     <= {ps2_clk_oe, ps2_data_oe};
      end
      if (errPrev) begin
         oeAfterErr    <= {ps2_clk_oe, ps2_data_oe};
         readyAfterErr <= tx_ready;
      end
      if (ps2_clk_oe && !clkOePrev) oeRiseCyc <= cyc;
      errPrev   <= tx_err;
      clkOePrev <= ps2_clk_oe;
   end

   typedef struct {
      logic [7:0] data;
      bit         ackLow;
      logic       expParity;
      int         expDone;
      int         expErr;
      logic [1:0] expCode;
   } vec_t;

   vec_t        vecs[4];
   int          passed = 0, total = 0;
   int          inhCnt, setupCnt;
   bit          readyHigh;
   logic [10:0] lineBits;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic startTx(input logic [7:0] b);
      @(negedge clk);
      tx_data  = b;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
   endtask

   // Call on the first INHIBIT cycle; returns on the first clock-release cycle.
   task automatic measurePhases();
      inhCnt = 0;
      setupCnt = 0;
      readyHigh = 0;
      while (ps2_clk_oe && !ps2_data_oe && inhCnt < 10000) begin
         if (tx_ready) readyHigh = 1;
         inhCnt++;
         @(negedge clk);
      end
      while (ps2_clk_oe && ps2_data_oe && setupCnt < 1000) begin
         if (tx_ready) readyHigh = 1;
         setupCnt++;
         @(negedge clk);
      end
   endtask

   // Keyboard clocks n falling edges, reading the line at the end of each low phase.
   task automatic deviceEdges(input int n, input bit ackLow);
      repeat (5) @(negedge clk);
      for (int k = 0; k < n; k++) begin
         devClkLow = 1'b1;
         repeat (HALF) @(negedge clk);
         lineBits[k] = ps2_data_in;
         devClkLow = 1'b0;
         repeat (HALF / 2) @(negedge clk);
         if (k == 9 && ackLow) devDataLow = 1'b1;
         repeat (HALF / 2) @(negedge clk);
         if (k == 10) devDataLow = 1'b0;
      end
   endtask

   initial begin
      int doneBefore, errBefore, n, oeHigh;

      vecs[0] = '{CMD_SET_LED,   1'b1, 1'b1, 1, 0, ERR_NONE};
      vecs[1] = '{CMD_ENABLE,    1'b1, 1'b0, 1, 0, ERR_NONE};
      vecs[2] = '{CMD_TYPEMATIC, 1'b0, 1'b1, 0, 1, ERR_NOACK};
      vecs[3] = '{8'h01,         1'b1, 1'b0, 1, 0, ERR_NONE};

      repeat (3) @(negedge clk);
      check("reset_outputs", {tx_ready, tx_busy, tx_done, tx_err, ps2_clk_oe, ps2_data_oe, err_code}, 8'h80);
      reset_n = 1'b1;
      repeat (5) @(negedge clk);

      for (int i = 0; i < 4; i++) begin
         doneBefore = doneTotal;
         errBefore  = errTotal;
         startTx(vecs[i].data);
         measurePhases();
         check("inhibit_len", inhCnt, INH);
         check("setup_len", setupCnt, SET);
         check("ready_low_while_busy", readyHigh, 0);
         deviceEdges(11, vecs[i].ackLow);
         repeat (30) @(negedge clk);
         check("data_bits", lineBits[7:0], vecs[i].data);
         check("parity_bit", lineBits[8], vecs[i].expParity);
         check("stop_bit", lineBits[9], 1);
         check("done_cycles", doneTotal - doneBefore, vecs[i].expDone);
         check("err_cycles", errTotal - errBefore, vecs[i].expErr);
         if (vecs[i].expErr != 0) begin
            check("err_code", lastErrCode, vecs[i].expCode);
            check("oe_at_err", oeAtErr, 0);
            check("oe_after_err", oeAfterErr, 0);
            check("ready_after_err", readyAfterErr, 1);
         end
      end

      // Device never clocks: start timeout counted from clock release.
      startTx(8'h5A);
      measurePhases();
      n = 0;
      while (!tx_err && n < 5000) begin
         @(negedge clk);
         n++;
      end
      check("start_timeout_cycles", n, START_TO);
      check("start_timeout_code", err_code, ERR_START_TO);

      // Device stops mid-frame: packet timeout.
      repeat (5) @(negedge clk);
      startTx(8'h12);
      measurePhases();
      deviceEdges(3, 1'b0);
      n = 0;
      while (!tx_err && n < 5000) begin
         @(negedge clk);
         n++;
      end
      check("pkt_timeout_code", err_code, ERR_PKT_TO);

      // Reset while bit 4 is on the line; a tx_valid pulse while busy is dropped.
      repeat (5) @(negedge clk);
      doneBefore = doneTotal;
      errBefore  = errTotal;
      startTx(8'h55);
      measurePhases();
      deviceEdges(3, 1'b0);
      tx_data  = 8'hAA;
      tx_valid = 1'b1;
      repeat (3) @(negedge clk);
      tx_valid = 1'b0;
      deviceEdges(2, 1'b0);
      check("busy_before_reset", tx_busy, 1);
      reset_n = 1'b0;
      @(negedge clk);
      check("reset_mid_oe", {ps2_clk_oe, ps2_data_oe}, 0);
      check("reset_mid_busy", tx_busy, 0);
      reset_n = 1'b1;
      oeHigh = 0;
      repeat (200) begin
         @(negedge clk);
         if (ps2_clk_oe) oeHigh++;
      end
      check("no_send_after_reset", oeHigh, 0);
      check("reset_no_done", doneTotal - doneBefore, 0);
      check("reset_no_err", errTotal - errBefore, 0);

      // Back-to-back with tx_valid held: 0xFF then 0x00.
      @(negedge clk);
      tx_data  = CMD_RESET;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_data = 8'h00;
      measurePhases();
      deviceEdges(11, 1'b1);
      check("ff_data_bits", lineBits[7:0], 8'hFF);
      check("ff_parity", lineBits[8], 1);
      n = 0;
      while (!ps2_clk_oe && n < 200) begin
         @(negedge clk);
         n++;
      end
      tx_valid = 1'b0;
      measurePhases();
      check("b2b_accept_gap", oeRiseCyc - doneCyc, 2);
      check("ready_at_done", readyAtDone, 0);
      deviceEdges(11, 1'b1);
      repeat (30) @(negedge clk);
      check("zero_data_bits", lineBits[7:0], 8'h00);
      check("zero_parity", lineBits[8], 1);
      check("zero_acked", tx_ready, 1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
